lfsr_msb_test_ctrl: RTL
=======================

// Module: lfsr_msb_test_ctrl
// PURPOSE
//  Sequences one LFSR randomness test run: seeds the LFSR, clears the MSB ones-counter,
//  enables both for exactly RUN_LEN cycles, then captures the ones count and checks it
//  against a window. Sits between host start/seed logic and the LFSR + MSB_counter
//  datapath. It drives the counter's max_tick (clear) and gated msb inputs.
// PARAMETERS
//  LFSR_W    16     LFSR seed width
//  CNT_W     17     ones-counter width; must match the MSB counter output
//  RUN_LEN   65535  cycles per run; full period of a 16-bit maximal LFSR; must be >=1
//  MIN_ONES  32700  lowest passing ones count (inclusive)
//  MAX_ONES  32836  highest passing ones count (inclusive)
// PORTS
//  clk         in   1       system clock, rising edge
//  reset       in   1       synchronous, active-high
//  start       in   1       begin a run; sampled only in IDLE
//  abort       in   1       cancel the current run; no done is issued
//  seed        in   LFSR_W  seed, latched on the accepted start
//  lfsr_msb    in   1       MSB of the LFSR output
//  cnt_value   in   CNT_W   MSB counter output
//  lfsr_load   out  1       one-cycle pulse that loads lfsr_seed into the LFSR
//  lfsr_seed   out  LFSR_W  latched seed; 0 is replaced by 1
//  lfsr_en     out  1       LFSR step enable
//  cnt_clr     out  1       one-cycle clear pulse to the counter max_tick
//  cnt_msb     out  1       gated msb to the counter: lfsr_msb & (state==RUN)
//  busy        out  1       high in every state except IDLE
//  done        out  1       one-cycle pulse when a result is valid
//  pass        out  1       result of the last completed run (held)
//  ones_count  out  CNT_W   captured count from the last completed run (held)
// BEHAVIOUR
//  Reset: state=IDLE. All outputs are 0, including lfsr_seed, pass and ones_count.
//   Reset overrides start and abort in the same cycle.
//  FSM states: IDLE, LOAD, CLEAR, RUN, SETTLE, CHECK. Outputs are decoded from the
//   registered state (Moore), except cnt_msb, which is gated combinationally.
//  IDLE: on start=1 at edge T, latch seed (0 -> 1 to avoid LFSR lock-up) and go to LOAD.
//  LOAD  (cycle T+1): lfsr_load=1. Next state is CLEAR.
//  CLEAR (T+2): cnt_clr=1. Next state is RUN. The run counter is zeroed.
//  RUN   (T+3 .. T+2+RUN_LEN): lfsr_en=1 and cnt_msb=lfsr_msb.
//   - The run counter has width $clog2(RUN_LEN+1) and increments each cycle.
//   - When the count equals RUN_LEN-1, the next state is SETTLE.
//   - lfsr_en is high for exactly RUN_LEN cycles.
//  SETTLE (T+3+RUN_LEN): lfsr_en=0 and cnt_msb=0. This absorbs the counter's
//   one-cycle register latency.
//  CHECK (T+4+RUN_LEN):
//   - done=1.
//   - ones_count<=cnt_value.
//   - pass<=(cnt_value>=MIN_ONES && cnt_value<=MAX_ONES), an unsigned CNT_W compare.
//   - Both outputs are visible from the next cycle. Next state is IDLE.
//  Back-to-back: start is accepted in IDLE the cycle after CHECK. The minimum
//   start-to-start spacing is RUN_LEN+5 cycles.
//  start while busy: ignored and not queued. seed changes while busy are ignored.
//  abort=1 in any non-IDLE state:
//   - Next state is IDLE. No done is issued.
//   - pass and ones_count keep their prior values.
//   - lfsr_en drops on the next cycle.
//  abort in IDLE: no effect. abort and start together in IDLE: abort wins, and the
//   start is dropped.
//  An illegal state encoding recovers to IDLE on the next cycle.
// TESTING (bench with RUN_LEN=8, MIN_ONES=4, MAX_ONES=8, behavioural 17-bit counter)
//  1. Hold reset for 3 cycles -> all outputs 0, busy=0. start during reset is ignored.
//  2. start at T with seed=16'hACE1 and lfsr_msb tied 1 -> lfsr_load at T+1 with
//     lfsr_seed=ACE1. cnt_clr at T+2. lfsr_en for exactly 8 cycles. done at T+12.
//     ones_count=8, pass=1.
//  3. Same as 2 with lfsr_msb tied 0 -> ones_count=0, pass=0. Alternating msb ->
//     ones_count=4, pass=1 (inclusive lower bound).
//  4. seed=16'h0000 -> lfsr_seed=16'h0001 during LOAD.
//  5. start pulsed again mid-RUN -> ignored, exactly one done. abort at RUN cycle 3 ->
//     busy=0 next cycle, no done, prior pass and ones_count unchanged.
//  6. reset asserted mid-RUN -> every output is 0 on the next cycle. A following start
//     runs normally.

Source files
------------

// File: rtl/lfsr_msb_test_ctrl.sv
// rtl/lfsr_msb_test_ctrl.sv - sequencer for one LFSR MSB randomness test run
// Seeds the LFSR, clears the ones-counter, runs RUN_LEN cycles, then captures and windows the count.
module lfsr_msb_test_ctrl #(
   parameter int LFSR_W   = 16,
   parameter int CNT_W    = 17,
   parameter int RUN_LEN  = 65535,
   parameter int MIN_ONES = 32700,
   parameter int MAX_ONES = 32836
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic              i_abort,
   input  logic [LFSR_W-1:0] i_seed,
   input  logic              i_lfsr_msb,
   input  logic [CNT_W-1:0]  i_cnt_value,
   output logic              o_lfsr_load,
   output logic [LFSR_W-1:0] o_lfsr_seed,
   output logic              o_lfsr_en,
   output logic              o_cnt_clr,
   output logic              o_cnt_msb,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_pass,
   output logic [CNT_W-1:0]  o_ones_count
);

   localparam int RC_W = $clog2(RUN_LEN + 1);
   localparam logic [RC_W-1:0]  RUN_LAST = RC_W'(RUN_LEN - 1);
   localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_ONES);
   localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_ONES);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_CLEAR  = 3'd2,
      S_RUN    = 3'd3,
      S_SETTLE = 3'd4,
      S_CHECK  = 3'd5
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [RC_W-1:0]   r_run_cnt;
   logic              r_lfsr_load;
   logic [LFSR_W-1:0] r_lfsr_seed;
   logic              r_lfsr_en;
   logic              r_cnt_clr;
   logic              r_busy;
   logic              r_done;
   logic              r_pass;
   logic [CNT_W-1:0]  r_ones_count;

   always_comb begin
      w_next = S_IDLE;
      case (r_state)
         S_IDLE:   w_next = i_start ? S_LOAD : S_IDLE;
         S_LOAD:   w_next = S_CLEAR;
         S_CLEAR:  w_next = S_RUN;
         S_RUN:    w_next = (r_run_cnt == RUN_LAST) ? S_SETTLE : S_RUN;
         S_SETTLE: w_next = S_CHECK;
         S_CHECK:  w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
      // Abort from any state lands in IDLE; in IDLE it also drops a coincident start.
      if (i_abort) begin
         w_next = S_IDLE;
      end
   end

   // Outputs are registered from the next state so they line up with r_state.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_run_cnt    <= '0;
         r_lfsr_load  <= 1'b0;
         r_lfsr_seed  <= '0;
         r_lfsr_en    <= 1'b0;
         r_cnt_clr    <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_ones_count <= '0;
      end else begin
         r_state     <= w_next;
         r_lfsr_load <= (w_next == S_LOAD);
         r_cnt_clr   <= (w_next == S_CLEAR);
         r_lfsr_en   <= (w_next == S_RUN);
         r_busy      <= (w_next != S_IDLE);
         r_done      <= (w_next == S_CHECK);
         if (r_state == S_IDLE && w_next == S_LOAD) begin
            r_lfsr_seed <= (i_seed == '0) ? LFSR_W'(1) : i_seed;
         end
         if (r_state == S_CLEAR) begin
            r_run_cnt <= '0;
         end else if (r_state == S_RUN) begin
            r_run_cnt <= r_run_cnt + RC_W'(1);
         end
         if (r_state == S_CHECK && !i_abort) begin
            r_ones_count <= i_cnt_value;
            r_pass       <= (i_cnt_value >= MIN_C) && (i_cnt_value <= MAX_C);
         end
      end
   end

   assign o_lfsr_load  = r_lfsr_load;
   assign o_lfsr_seed  = r_lfsr_seed;
   assign o_lfsr_en    = r_lfsr_en;
   assign o_cnt_clr    = r_cnt_clr;
   assign o_cnt_msb    = i_lfsr_msb & (r_state == S_RUN);
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_pass       = r_pass;
   assign o_ones_count = r_ones_count;

endmodule
